// File: rtl/plreg_arbiter.sv
// plreg_arbiter
//
// Shared register loaded by one of four requesters, picked round-robin.
// Each served request walks IDLE -> LOAD -> DONE: the winner is picked in
// IDLE, its data slice is captured in LOAD, and DONE pulses a one-hot ack,
// advances the priority pointer and counts the completed load.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   req       per-requester load request (req[i] is requester i)
//   din       flat requester data, requester i owns din[i*WIDTH +: WIDTH]
//   clr       synchronous clear of the shared register, aborts any grant
//   q         shared register contents
//   ack       one-hot completion pulse to the served requester
//   grant_id  index of the granted requester, meaningful while busy=1
//   busy      high while a grant is in progress (LOAD or DONE)
//   loads     count of completed loads, wraps 255 -> 0

module plreg_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  input  logic               clr,
  output logic [WIDTH-1:0]   q,
  output logic [3:0]         ack,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic [7:0]         loads
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grantId_q, grantId_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       loads_q, loads_d;

  logic [1:0]       winner;
  logic             found;
  logic [1:0]       cand;

  // Round-robin pick: scan from the requester just after the last one
  // served, ending with the last-served requester itself so it gets the
  // lowest priority when others are also waiting.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k < 5; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // State register and datapath registers. Reset returns the pointer to 3
  // so requester 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grantId_q <= '0;
      ptr_q     <= 2'd3;
      data_q    <= '0;
      loads_q   <= '0;
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      loads_q   <= loads_d;
    end
  end

  // Next-state logic. A clear overrides everything: it empties the register
  // and drops back to IDLE, leaving pointer and load count untouched so an
  // aborted requester is simply arbitrated again later.
  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    loads_d   = loads_q;
    if (clr) begin
      state_d = IDLE;
      data_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grantId_d = winner;
            state_d   = LOAD;
          end
        end
        LOAD: begin
          data_d  = din[grantId_q*WIDTH +: WIDTH];
          state_d = DONE;
        end
        DONE: begin
          ptr_d   = grantId_q;
          loads_d = loads_q + 8'd1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs. The ack is suppressed when clr or reset is present in the DONE
  // cycle, because that edge discards the completion instead of retiring it.
  always_comb begin
    ack = '0;
    if (state_q == DONE && !clr && !reset) begin
      ack[grantId_q] = 1'b1;
    end
    busy = (state_q != IDLE);
  end

  assign q        = data_q;
  assign grant_id = grantId_q;
  assign loads    = loads_q;

endmodule

// File: tb/tb_plreg_arbiter.sv
// tb_plreg_arbiter
//
// Directed scenarios for single load, round-robin order, clear abort,
// dropped request, counter wrap and reset during DONE, followed by a
// randomized phase where a transaction-level reference model predicts every
// ack and pushes it into a scoreboard queue that a negedge monitor drains.

module tb_plreg_arbiter;

  localparam int WIDTH = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] din;
  logic               clr;
  logic [WIDTH-1:0]   q;
  logic [3:0]         ack;
  logic [1:0]         grant_id;
  logic               busy;
  logic [7:0]         loads;

  int tests = 0;
  int fails = 0;
  bit sbEnable = 1'b0;

  typedef struct {
    int         id;
    logic [3:0] data;
    logic [7:0] loadsNow;
  } exp_t;

  exp_t sbQ[$];
  exp_t monExp;
  logic [3:0] monOneHot;

  plreg_arbiter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .din      (din),
    .clr      (clr),
    .q        (q),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .loads    (loads)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] d, input logic c);
    req = r;
    din = d;
    clr = c;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  // Waits a bounded number of cycles for an ack, checks it and q, and
  // returns just after the edge that retires the DONE state.
  task automatic waitAckCheck(input string name, input logic [3:0] expAck,
                              input logic [3:0] expQ);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      midCycle();
      if (ack != 4'b0000) begin
        seen = 1'b1;
        checkOutput({name, "_ack"}, 32'(ack), 32'(expAck));
        checkOutput({name, "_q"}, 32'(q), 32'(expQ));
      end
      nextCycle();
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got no ack required %0h", name, expAck);
    end
  endtask

  // Scoreboard monitor: every ack seen mid-cycle must match the oldest
  // prediction from the reference model.
  always @(negedge clk) begin
    if (sbEnable && !reset && ack != 4'b0000) begin
      if (sbQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL sb_unexpected: got ack %0h required none", ack);
      end else begin
        monExp    = sbQ.pop_front();
        monOneHot = 4'b0001 << monExp.id;
        checkOutput("sb_ack", 32'(ack), 32'(monOneHot));
        checkOutput("sb_q", 32'(q), 32'(monExp.data));
        checkOutput("sb_loads", 32'(loads), 32'(monExp.loadsNow));
      end
    end
  end

  // Reference model state for the random phase.
  int         mPtr;
  int         mLoads;
  bit         mInflight;
  int         mAge;
  int         mId;
  logic [3:0] mQ;
  logic [3:0] reqReg;
  logic [15:0] dinReg;
  int         ackedId;
  logic       cRand;
  exp_t       pushExp;

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000, 16'h0000, 1'b0);

    // Single request from requester 2.
    doReset();
    applyStimulus(4'b0100, 16'h0C00, 1'b0);
    midCycle();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_q", 32'(q), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_loads", 32'(loads), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    nextCycle();
    midCycle();
    checkOutput("single_busy", 32'(busy), 32'd1);
    checkOutput("single_grant", 32'(grant_id), 32'd2);
    checkOutput("single_ack_load", 32'(ack), 32'd0);
    nextCycle();
    midCycle();
    checkOutput("single_q", 32'(q), 32'hC);
    checkOutput("single_ack", 32'(ack), 32'b0100);
    nextCycle();
    applyStimulus(4'b0000, 16'h0C00, 1'b0);
    midCycle();
    checkOutput("single_ack_after", 32'(ack), 32'd0);
    checkOutput("single_loads", 32'(loads), 32'd1);
    checkOutput("single_idle", 32'(busy), 32'd0);

    // Round-robin with all four requesting continuously.
    doReset();
    applyStimulus(4'b1111, 16'h4321, 1'b0);
    for (int i = 0; i < 5; i++) begin
      waitAckCheck("rr", 4'(4'b0001 << (i % 4)), 4'((i % 4) + 1));
    end
    applyStimulus(4'b0000, 16'h4321, 1'b0);
    midCycle();
    checkOutput("rr_loads", 32'(loads), 32'd5);

    // Clear during LOAD aborts requester 1, which is served afterwards.
    doReset();
    applyStimulus(4'b0100, 16'h05A0, 1'b0);
    waitAckCheck("clr_pre", 4'b0100, 4'h5);
    applyStimulus(4'b0010, 16'h05A0, 1'b0);
    nextCycle();
    applyStimulus(4'b0010, 16'h05A0, 1'b1);
    midCycle();
    checkOutput("clr_grant", 32'(grant_id), 32'd1);
    checkOutput("clr_ack_load", 32'(ack), 32'd0);
    nextCycle();
    applyStimulus(4'b0010, 16'h05A0, 1'b0);
    midCycle();
    checkOutput("clr_q", 32'(q), 32'd0);
    checkOutput("clr_loads", 32'(loads), 32'd1);
    checkOutput("clr_busy", 32'(busy), 32'd0);
    waitAckCheck("clr_retry", 4'b0010, 4'hA);
    applyStimulus(4'b0000, 16'h05A0, 1'b0);
    midCycle();
    checkOutput("clr_loads_after", 32'(loads), 32'd2);

    // Request dropped right after the grant still completes.
    doReset();
    applyStimulus(4'b1000, 16'h5000, 1'b0);
    nextCycle();
    applyStimulus(4'b0000, 16'h5000, 1'b0);
    waitAckCheck("drop", 4'b1000, 4'h5);
    midCycle();
    checkOutput("drop_loads", 32'(loads), 32'd1);

    // Load counter wraps after 256 completions without disturbing order.
    doReset();
    applyStimulus(4'b1111, 16'h4321, 1'b0);
    for (int n = 0; n < 256; n++) begin
      waitAckCheck("wrap", 4'(4'b0001 << (n % 4)), 4'((n % 4) + 1));
    end
    midCycle();
    checkOutput("wrap_loads", 32'(loads), 32'd0);
    waitAckCheck("wrap_next", 4'b0001, 4'h1);
    applyStimulus(4'b0000, 16'h4321, 1'b0);
    midCycle();
    checkOutput("wrap_loads_next", 32'(loads), 32'd1);

    // Reset asserted during DONE discards the load and restores priority.
    doReset();
    applyStimulus(4'b0010, 16'h4321, 1'b0);
    waitAckCheck("rstmid_pre", 4'b0010, 4'h2);
    applyStimulus(4'b1111, 16'h4321, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    midCycle();
    checkOutput("rstmid_busy", 32'(busy), 32'd1);
    checkOutput("rstmid_grant", 32'(grant_id), 32'd2);
    checkOutput("rstmid_ack", 32'(ack), 32'd0);
    nextCycle();
    reset = 1'b0;
    midCycle();
    checkOutput("rstmid_q", 32'(q), 32'd0);
    checkOutput("rstmid_loads", 32'(loads), 32'd0);
    checkOutput("rstmid_grant0", 32'(grant_id), 32'd0);
    checkOutput("rstmid_idle", 32'(busy), 32'd0);
    checkOutput("rstmid_ack0", 32'(ack), 32'd0);
    waitAckCheck("rstmid_first", 4'b0001, 4'h1);
    applyStimulus(4'b0000, 16'h4321, 1'b0);

    // Randomized phase against the transaction-level model.
    doReset();
    mPtr      = 3;
    mLoads    = 0;
    mInflight = 1'b0;
    mAge      = 0;
    mId       = 0;
    mQ        = 4'h0;
    reqReg    = 4'b0000;
    dinReg    = 16'h0000;
    ackedId   = -1;
    sbEnable  = 1'b1;
    for (int cyc = 0; cyc < 3012; cyc++) begin
      if (cyc < 3000) begin
        if (ackedId >= 0) begin
          if ($urandom % 2 == 0) reqReg[ackedId] = 1'b0;
          else dinReg[ackedId*4 +: 4] = 4'($urandom);
          ackedId = -1;
        end
        for (int i = 0; i < 4; i++) begin
          if (!reqReg[i] && !(mInflight && mId == i) && $urandom % 4 == 0) begin
            reqReg[i] = 1'b1;
            dinReg[i*4 +: 4] = 4'($urandom);
          end else if (reqReg[i] && mInflight && mId == i && $urandom % 16 == 0) begin
            reqReg[i] = 1'b0;
          end
        end
        cRand = ($urandom % 20 == 0);
      end else begin
        reqReg  = 4'b0000;
        cRand   = 1'b0;
        ackedId = -1;
      end
      applyStimulus(reqReg, dinReg, cRand);

      if (mInflight && mAge == 2 && !cRand) begin
        pushExp.id       = mId;
        pushExp.data     = mQ;
        pushExp.loadsNow = 8'(mLoads);
        sbQ.push_back(pushExp);
        ackedId = mId;
      end

      if (cRand) begin
        mInflight = 1'b0;
        mQ        = 4'h0;
      end else if (!mInflight) begin
        for (int k = 1; k <= 4; k++) begin
          if (!mInflight && reqReg[(mPtr + k) % 4]) begin
            mId       = (mPtr + k) % 4;
            mInflight = 1'b1;
            mAge      = 1;
          end
        end
      end else if (mAge == 1) begin
        mQ   = dinReg[mId*4 +: 4];
        mAge = 2;
      end else begin
        mPtr      = mId;
        mLoads    = (mLoads + 1) % 256;
        mInflight = 1'b0;
      end
      nextCycle();
    end
    midCycle();
    checkOutput("sb_drain", 32'(sbQ.size()), 32'd0);
    checkOutput("rand_loads", 32'(loads), 32'(mLoads));
    checkOutput("rand_q", 32'(q), 32'(mQ));
    sbEnable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
